pll_reset_seq: RTL
==================

# pll_reset_seq

Reset sequencer placed directly downstream of the SDRAM PLL, clocked by the PLL's 50 MHz reference clock. Pulses the PLL reset and synchronizes and qualifies the PLL `locked` flag. Holds the SDRAM controller and video logic in reset until lock has been stable and the SDRAM power-up delay has elapsed. Re-runs the sequence on lock loss, and escalates to a sticky fault after repeated failures.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: length of the `pll_rst` pulse, in cycles.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK without lock before a retry.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required to qualify lock.
- `POWERUP_CYCLES`, 10000: SDRAM power-up hold (200 µs at 50 MHz).
- `MAX_RETRIES`, 7: failed attempts tolerated before FAULT; legal range 0..15.

Ports:
- `refclk` input 1: 50 MHz reference clock; the only clock.
- `rst_n` input 1: reset; synchronous, active-low.
- `locked` input 1: PLL lock flag; asynchronous to `refclk`.
- `pll_rst` output 1: active-high reset to the PLL.
- `sys_rst_n` output 1: active-low reset to downstream logic.
- `ready` output 1: high in RUN only.
- `fault` output 1: sticky failure flag.
- `retry_count` output 4: failed attempts so far; saturates at 15.

## Operation
- `locked` passes through a 2-flop synchronizer; both flops reset to 0. The synchronized signal is `locked_s`.
- There is one shared cycle counter, cleared on every state entry. There is one retry counter.
- All outputs are registered decodes of the next state, so they change in the same edge as the state.
- States and transitions:
  - RESET_PLL: `pll_rst`=1. After exactly `RST_PULSE_CYCLES` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: `locked_s`=1 goes to STABLE. Reaching `LOCK_TIMEOUT_CYCLES` with no lock is a *failure*.
  - STABLE: `locked_s`=0 returns to WAIT_LOCK; this is not a failure, and the timeout restarts. `LOCK_STABLE_CYCLES` consecutive high cycles go to POWERUP.
  - POWERUP: `sys_rst_n` stays 0. After `POWERUP_CYCLES`, go to RUN.
  - RUN: `sys_rst_n`=1 and `ready`=1.
  - FAULT: `pll_rst`=0, `sys_rst_n`=0, `fault`=1. FAULT is left only by `rst_n`=0.
- Lock loss (`locked_s`=0) while in POWERUP or RUN is a *failure*. In RUN, `sys_rst_n` and `ready` drop on the same edge the loss is sampled.
- On a failure:
  - If `retry_count` == `MAX_RETRIES`, go to FAULT.
  - Otherwise increment `retry_count` (saturating) and go to RESET_PLL.
- `retry_count` is cleared only by reset. Success does not clear it.
- Counters have no wrap-around: each compare ends its state before the counter can overflow. The counter width is clog2 of the largest parameter, plus 1.

## Timing
- Reset values: state RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_count`=0, counter 0.
- Reset mid-operation has the same effect from any state, including FAULT. The RESET_PLL pulse restarts its full length after `rst_n` returns high.
- Lock-to-release latency: `locked` rising to `sys_rst_n` rising takes 2 synchronizer cycles + 1 WAIT_LOCK decode cycle + `LOCK_STABLE_CYCLES` + `POWERUP_CYCLES`. Each exact cycle count must match the parameter; no off-by-one is allowed.
- Lock-loss latency: `locked` falling to `sys_rst_n` falling takes 3 cycles (2 synchronizer cycles + 1 register).
- Simultaneous events:
  - A timeout expiring in the same cycle `locked_s` rises counts as a lock, not a timeout.
  - A lock loss in the last POWERUP cycle is a failure.
- `pll_rst` is never asserted in WAIT_LOCK, STABLE, POWERUP, RUN, or FAULT.

## Configuration
- Macro: `PLLSEQ_AUTO_RETRY_EN`.
- Defined: the retry behaviour exactly as described in Operation.
- Undefined: any failure goes directly to FAULT. `retry_count` stays 0, and `MAX_RETRIES` is ignored. The synchronizer, the STABLE bounce behaviour, and the timing are unchanged.

## Test plan
Test parameters: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `POWERUP_CYCLES`=10, `MAX_RETRIES`=2.
- Nominal bring-up: release `rst_n`; `pll_rst` is high for exactly 4 cycles. Raise `locked` 5 cycles later and hold it. `sys_rst_n`/`ready` rise exactly 2+1+8+10=21 cycles after `locked` rises. `retry_count`=0.
- Lock bounce: drop `locked` after 5 cycles of STABLE, then restore it. The state returns to WAIT_LOCK with no retry (`retry_count`=0). Release happens 21 cycles after the final rise.
- Timeout: keep `locked`=0. `pll_rst` re-pulses after 32 WAIT_LOCK cycles and `retry_count` goes 1, then 2. On the third timeout, `fault`=1, `pll_rst`=0, and `fault` stays 1 until `rst_n`=0.
- Lock loss in RUN: drop `locked`. `sys_rst_n`/`ready` fall 3 cycles later, `pll_rst` pulses for 4 cycles, and `retry_count`=1.
- Mid-sequence reset: assert `rst_n`=0 for 1 cycle during POWERUP. All outputs return to their reset values on that edge, and a full 4-cycle `pll_rst` pulse follows.
- Build without `PLLSEQ_AUTO_RETRY_EN`: the first timeout gives `fault`=1 with `retry_count`=0.

Source files
------------

// File: rtl/pll_reset_seq_if.sv
// PLL lock input plus the reset and status outputs of the PLL reset sequencer.
interface pll_reset_seq_if;
    localparam int unsigned RETRY_W = 4;

    logic               locked;
    logic               pll_rst;
    logic               sys_rst_n;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  locked,
        output pll_rst, sys_rst_n, ready, fault, retry_count
    );

    modport slave (
        output locked,
        input  pll_rst, sys_rst_n, ready, fault, retry_count
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, holds downstream reset through SDRAM power-up.
// Build option PLLSEQ_AUTO_RETRY_EN: retry up to MAX_RETRIES failures; without it any failure is fatal.
module pll_reset_seq #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned POWERUP_CYCLES      = 10000,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic            refclk,
    input  logic            rst_n,
    pll_reset_seq_if.master bus
);
    localparam int unsigned MAX_AB     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                         RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD     = (LOCK_STABLE_CYCLES > POWERUP_CYCLES) ?
                                         LOCK_STABLE_CYCLES : POWERUP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam int unsigned RETRY_W    = 4;

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_POWERUP   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic               lock_meta;
    logic               locked_s;
    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_nxt;
    logic               fail;
    logic               timed;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= bus.locked;
            locked_s  <= lock_meta;
        end
    end

    // Next state; a lock sample wins over a same-cycle timeout, a loss wins over POWERUP completion.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        fail      = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)                                   state_nxt = S_STABLE;
                else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) fail = 1'b1;
            end
            S_STABLE: begin
                if (!locked_s)                                  state_nxt = S_WAIT_LOCK;
                else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_nxt = S_POWERUP;
            end
            S_POWERUP: begin
                if (!locked_s)                              fail = 1'b1;
                else if (cnt == CNT_W'(POWERUP_CYCLES - 1)) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) fail = 1'b1;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_RESET_PLL;
            end
        endcase

`ifdef PLLSEQ_AUTO_RETRY_EN
        if (fail) begin
            if (retry == RETRY_W'(MAX_RETRIES)) begin
                state_nxt = S_FAULT;
            end else begin
                state_nxt = S_RESET_PLL;
                if (retry != {RETRY_W{1'b1}}) retry_nxt = retry + RETRY_W'(1);
            end
        end
`else
        if (fail) state_nxt = S_FAULT;
`endif
    end

    // Shared counter: cleared on state entry, frozen in the untimed RUN and FAULT states.
    always_comb begin
        timed = (state_nxt != S_RUN) && (state_nxt != S_FAULT);
        if (state_nxt != state) cnt_nxt = '0;
        else if (timed)         cnt_nxt = cnt + CNT_W'(1);
        else                    cnt_nxt = cnt;
    end

`ifndef PLLSEQ_AUTO_RETRY_EN
    logic unused_max_retries;
    assign unused_max_retries = ^RETRY_W'(MAX_RETRIES);
`endif

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state           <= S_RESET_PLL;
            cnt             <= '0;
            retry           <= '0;
            bus.pll_rst     <= 1'b1;
            bus.sys_rst_n   <= 1'b0;
            bus.ready       <= 1'b0;
            bus.fault       <= 1'b0;
            bus.retry_count <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            retry           <= retry_nxt;
            bus.pll_rst     <= (state_nxt == S_RESET_PLL);
            bus.sys_rst_n   <= (state_nxt == S_RUN);
            bus.ready       <= (state_nxt == S_RUN);
            bus.fault       <= (state_nxt == S_FAULT);
            bus.retry_count <= retry_nxt;
        end
    end
endmodule
